// File: rtl/tinyarch_pkg.sv
// Shared types and constants for the tinyarch fetch/decode slice.
package tinyarch_pkg;

  typedef enum logic [1:0] {
    JM_STEP    = 2'd0,
    JM_SKIP_NZ = 2'd1,
    JM_SKIP    = 2'd2,
    JM_JUMP    = 2'd3
  } jump_mode_e;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_RUN  = 2'd1,
    FS_DONE = 2'd2
  } fetch_state_e;

  localparam logic [8:0]  HALT_INSTR = 9'h1FF;
  localparam logic [15:0] CNT_MAX    = 16'hFFFF;

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC select: step, conditional/unconditional skip or absolute jump.
module pc_next
  import tinyarch_pkg::*;
#(
  parameter int PC_W = 10
) (
  input  logic [PC_W-1:0] pc_i,
  input  jump_mode_e      jump_mode_i,
  input  logic            alu_nonzero_i,
  input  logic [PC_W-1:0] jump_target_i,
  output logic [PC_W-1:0] pc_next_o
);

  logic [PC_W-1:0] pc_plus1_s;
  logic [PC_W-1:0] pc_plus2_s;

  // Additions wrap silently modulo 2**PC_W.
  assign pc_plus1_s = pc_i + PC_W'(1);
  assign pc_plus2_s = pc_i + PC_W'(2);

  always_comb begin
    pc_next_o = pc_plus1_s;
    case (jump_mode_i)
      JM_STEP:    pc_next_o = pc_plus1_s;
      JM_SKIP_NZ: pc_next_o = alu_nonzero_i ? pc_plus2_s : pc_plus1_s;
      JM_SKIP:    pc_next_o = pc_plus2_s;
      JM_JUMP:    pc_next_o = jump_target_i;
      default:    pc_next_o = pc_plus1_s;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// PC register, fetch state machine and start/done handshake feeding decode.
// Optional instr_count output enabled by defining FETCH_INSTR_COUNT_EN.
module fetch_unit
  import tinyarch_pkg::*;
#(
  parameter int PC_W    = 10,
  parameter int INSTR_W = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         jump_mode,
  input  logic               alu_nonzero,
  input  logic [PC_W-1:0]    jump_target,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [PC_W-1:0]    rom_addr,
  output logic [INSTR_W-1:0] instr,
  output logic               finished,
  output logic               done
`ifdef FETCH_INSTR_COUNT_EN
  ,
  output logic [15:0]        instr_count
`endif
);

  localparam logic [INSTR_W-1:0] HALT_W = INSTR_W'(HALT_INSTR);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_step_s;
  logic            start_q;
  logic            done_q, done_d;
  logic            start_rise_s;
  logic            is_halt_s;

  assign start_rise_s = start & ~start_q;
  assign is_halt_s    = (rom_data == HALT_W);

  pc_next #(.PC_W(PC_W)) u_pc_next (
    .pc_i          (pc_q),
    .jump_mode_i   (jump_mode_e'(jump_mode)),
    .alu_nonzero_i (alu_nonzero),
    .jump_target_i (jump_target),
    .pc_next_o     (pc_step_s)
  );

  // Halt wins over any jump_mode; the PC stays on the halt instruction.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    done_d  = 1'b0;
    case (state_q)
      FS_IDLE, FS_DONE: begin
        if (start_rise_s) begin
          state_d = FS_RUN;
          pc_d    = '0;
        end else begin
          state_d = state_q;
        end
      end
      FS_RUN: begin
        if (is_halt_s) begin
          state_d = FS_DONE;
          done_d  = 1'b1;
        end else begin
          pc_d = pc_step_s;
        end
      end
      default: begin
        state_d = FS_IDLE;
        pc_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FS_IDLE;
      pc_q    <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      start_q <= start;
      done_q  <= done_d;
    end
  end

  assign rom_addr = pc_q;
  assign instr    = (state_q == FS_RUN) ? rom_data : HALT_W;
  assign finished = (state_q == FS_DONE);
  assign done     = done_q;

`ifdef FETCH_INSTR_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Counts executed (non-halt) RUN cycles, saturating; cleared when a run starts.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_q != FS_RUN) && start_rise_s) begin
      cnt_d = 16'd0;
    end else if ((state_q == FS_RUN) && !is_halt_s && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign instr_count = cnt_q;
`endif

endmodule
